// File: rtl/rob_commit_if.sv
// ROB head / retire-side bundle: ROB dequeue, ARAT write, freelist release,
// and retirement trace. The master modport is the commit stage.
interface rob_commit_if #(
    parameter int INSTRET_W = 64,
    parameter int PC_W      = 32,
    parameter int LREG_W    = 5,
    parameter int PREG_W    = 6
);
    logic                 head_valid;
    logic [PC_W-1:0]      head_pc;
    logic [31:0]          head_instr;
    logic [LREG_W-1:0]    head_lrd;
    logic [PREG_W-1:0]    head_prd;
    logic [PREG_W-1:0]    head_old_prd;
    logic                 head_pop;
    logic                 flush;
    logic                 arat_wr_en;
    logic [LREG_W-1:0]    arat_wr_lrd;
    logic [PREG_W-1:0]    arat_wr_prd;
    logic                 free_valid;
    logic [PREG_W-1:0]    free_preg;
    logic                 free_ready;
    logic                 commit_valid;
    logic [PC_W-1:0]      commit_pc;
    logic [31:0]          commit_instr;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  head_valid, head_pc, head_instr, head_lrd, head_prd,
               head_old_prd, flush, free_ready,
        output head_pop, arat_wr_en, arat_wr_lrd, arat_wr_prd,
               free_valid, free_preg, commit_valid, commit_pc,
               commit_instr, instret
    );

    modport slave (
        output head_valid, head_pc, head_instr, head_lrd, head_prd,
               head_old_prd, flush, free_ready,
        input  head_pop, arat_wr_en, arat_wr_lrd, arat_wr_prd,
               free_valid, free_preg, commit_valid, commit_pc,
               commit_instr, instret
    );
endinterface

// File: rtl/rob_commit.sv
// Commit stage: retires the ROB head into a one-entry buffer, updates the
// ARAT, releases the superseded physical register and counts instret.
module rob_commit #(
    parameter int INSTRET_W = 64,
    parameter int PC_W      = 32,
    parameter int LREG_W    = 5,
    parameter int PREG_W    = 6
) (
    input logic          clock,
    input logic          reset,
    rob_commit_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_WAITFREE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [LREG_W-1:0]    lrd_q, lrd_d;
    logic [PREG_W-1:0]    prd_q, prd_d;
    logic [PREG_W-1:0]    old_prd_q, old_prd_d;
    logic                 need_q, need_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic rel;
    logic pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            lrd_q     <= '0;
            prd_q     <= '0;
            old_prd_q <= '0;
            need_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            lrd_q     <= lrd_d;
            prd_q     <= prd_d;
            old_prd_q <= old_prd_d;
            need_q    <= need_d;
            instret_q <= instret_d;
        end
    end

    // A pending free must handshake before the buffer may be overwritten.
    always_comb begin
        rel       = (state_q == S_IDLE) | ~need_q | bus.free_ready;
        pop       = ~reset & bus.head_valid & ~bus.flush & rel;
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        lrd_d     = lrd_q;
        prd_d     = prd_q;
        old_prd_d = old_prd_q;
        need_d    = need_q;
        instret_d = instret_q + INSTRET_W'(pop);
        if (pop) begin
            state_d   = S_COMMIT;
            pc_d      = bus.head_pc;
            instr_d   = bus.head_instr;
            lrd_d     = bus.head_lrd;
            prd_d     = bus.head_prd;
            old_prd_d = bus.head_old_prd;
            need_d    = (bus.head_lrd != '0);
        end else begin
            unique case (state_q)
                S_IDLE:     state_d = S_IDLE;
                S_COMMIT,
                S_WAITFREE: state_d = rel ? S_IDLE : S_WAITFREE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.head_pop     = pop;
        bus.commit_valid = (state_q == S_COMMIT);
        bus.arat_wr_en   = (state_q == S_COMMIT) & need_q;
        bus.arat_wr_lrd  = lrd_q;
        bus.arat_wr_prd  = prd_q;
        bus.free_valid   = (state_q != S_IDLE) & need_q;
        bus.free_preg    = old_prd_q;
        bus.commit_pc    = pc_q;
        bus.commit_instr = instr_q;
        bus.instret      = instret_q;
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit; instret width 4 so wrap is reachable.
module tb_rob_commit;
    localparam int IW = 4;
    localparam int PW = 32;
    localparam int LW = 5;
    localparam int RW = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int vecs = 0;
    int errs = 0;
    logic [IW-1:0] exp_ir = '0;

    rob_commit_if #(.INSTRET_W(IW), .PC_W(PW), .LREG_W(LW), .PREG_W(RW)) bus ();

    rob_commit #(.INSTRET_W(IW), .PC_W(PW), .LREG_W(LW), .PREG_W(RW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [PW-1:0] pc,
                            input logic [LW-1:0] lrd, input logic [RW-1:0] prd,
                            input logic [RW-1:0] old);
        bus.head_valid   = v;
        bus.head_pc      = pc;
        bus.head_instr   = {pc[15:0], 16'h0013};
        bus.head_lrd     = lrd;
        bus.head_prd     = prd;
        bus.head_old_prd = old;
    endtask

    task automatic test_reset();
        set_head(1'b1, 32'h40, 5'd1, 6'd2, 6'd3);
        bus.flush = 1'b0;
        bus.free_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        vecs++;
        if (bus.head_pop !== 1'b0) begin
            errs++; $display("FAIL reset_pop got %b want 0", bus.head_pop);
        end
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_en, bus.free_valid} !== 3'b000) begin
            errs++; $display("FAIL reset_ctl got %b want 000",
                {bus.commit_valid, bus.arat_wr_en, bus.free_valid});
        end
        vecs++;
        if (bus.instret !== 4'd0 || bus.free_preg !== 6'd0 || bus.commit_pc !== 32'd0) begin
            errs++; $display("FAIL reset_data got ir=%0d preg=%0d pc=%h want 0",
                bus.instret, bus.free_preg, bus.commit_pc);
        end
        set_head(1'b0, 0, 0, 0, 0);
        reset = 1'b0;
        exp_ir = '0;
    endtask

    task automatic test_single();
        set_head(1'b1, 32'h100, 5'd5, 6'd40, 6'd12);
        bus.free_ready = 1'b1;
        #1;
        vecs++;
        if (bus.head_pop !== 1'b1) begin
            errs++; $display("FAIL single_pop got %b want 1", bus.head_pop);
        end
        step();
        exp_ir = exp_ir + 1;
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_en, bus.arat_wr_lrd, bus.arat_wr_prd}
            !== {1'b1, 1'b1, 5'd5, 6'd40}) begin
            errs++; $display("FAIL single_arat got cv=%b we=%b lrd=%0d prd=%0d want 1 1 5 40",
                bus.commit_valid, bus.arat_wr_en, bus.arat_wr_lrd, bus.arat_wr_prd);
        end
        vecs++;
        if ({bus.free_valid, bus.free_preg} !== {1'b1, 6'd12} ||
            bus.commit_pc !== 32'h100 || bus.instret !== exp_ir) begin
            errs++; $display("FAIL single_free got fv=%b preg=%0d pc=%h ir=%0d want 1 12 100 %0d",
                bus.free_valid, bus.free_preg, bus.commit_pc, bus.instret, exp_ir);
        end
        step();
        vecs++;
        if ({bus.commit_valid, bus.free_valid} !== 2'b00) begin
            errs++; $display("FAIL single_idle got cv=%b fv=%b want 0 0",
                bus.commit_valid, bus.free_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.free_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_head(1'b1, 32'h200 + 4 * i, LW'(i + 1), RW'(20 + i), RW'(30 + i));
            #1;
            vecs++;
            if (bus.head_pop !== 1'b1) begin
                errs++; $display("FAIL b2b_pop%0d got %b want 1", i, bus.head_pop);
            end
            if (i > 0) begin
                vecs++;
                if ({bus.commit_valid, bus.arat_wr_lrd, bus.free_preg}
                    !== {1'b1, LW'(i), RW'(29 + i)}) begin
                    errs++; $display("FAIL b2b_commit%0d got cv=%b lrd=%0d preg=%0d want 1 %0d %0d",
                        i, bus.commit_valid, bus.arat_wr_lrd, bus.free_preg, i, 29 + i);
                end
            end
            step();
            exp_ir = exp_ir + 1;
        end
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_lrd, bus.instret} !== {1'b1, 5'd4, exp_ir}) begin
            errs++; $display("FAIL b2b_last got cv=%b lrd=%0d ir=%0d want 1 4 %0d",
                bus.commit_valid, bus.arat_wr_lrd, bus.instret, exp_ir);
        end
        step();
    endtask

    task automatic test_stall();
        bus.free_ready = 1'b0;
        set_head(1'b1, 32'h300, 5'd7, 6'd20, 6'd33);
        step();
        exp_ir = exp_ir + 1;
        set_head(1'b1, 32'h304, 5'd8, 6'd21, 6'd34);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.head_pop, bus.free_valid, bus.free_preg}
            !== {1'b1, 1'b0, 1'b1, 6'd33}) begin
            errs++; $display("FAIL stall_commit got cv=%b pop=%b fv=%b preg=%0d want 1 0 1 33",
                bus.commit_valid, bus.head_pop, bus.free_valid, bus.free_preg);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            vecs++;
            if ({bus.commit_valid, bus.head_pop, bus.free_valid, bus.free_preg}
                !== {1'b0, 1'b0, 1'b1, 6'd33}) begin
                errs++; $display("FAIL stall_wait%0d got cv=%b pop=%b fv=%b preg=%0d want 0 0 1 33",
                    c, bus.commit_valid, bus.head_pop, bus.free_valid, bus.free_preg);
            end
        end
        bus.free_ready = 1'b1;
        #1;
        vecs++;
        if (bus.head_pop !== 1'b1) begin
            errs++; $display("FAIL stall_release_pop got %b want 1", bus.head_pop);
        end
        step();
        exp_ir = exp_ir + 1;
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_lrd, bus.free_preg} !== {1'b1, 5'd8, 6'd34}) begin
            errs++; $display("FAIL stall_next got cv=%b lrd=%0d preg=%0d want 1 8 34",
                bus.commit_valid, bus.arat_wr_lrd, bus.free_preg);
        end
        step();
    endtask

    task automatic test_x0();
        bus.free_ready = 1'b0;
        set_head(1'b1, 32'h400, 5'd0, 6'd9, 6'd0);
        step();
        exp_ir = exp_ir + 1;
        set_head(1'b1, 32'h404, 5'd3, 6'd11, 6'd9);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_en, bus.free_valid, bus.head_pop} !== 4'b1001) begin
            errs++; $display("FAIL x0_commit got cv=%b we=%b fv=%b pop=%b want 1 0 0 1",
                bus.commit_valid, bus.arat_wr_en, bus.free_valid, bus.head_pop);
        end
        step();
        exp_ir = exp_ir + 1;
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if ({bus.arat_wr_en, bus.arat_wr_lrd, bus.free_valid} !== {1'b1, 5'd3, 1'b1}) begin
            errs++; $display("FAIL x0_next got we=%b lrd=%0d fv=%b want 1 3 1",
                bus.arat_wr_en, bus.arat_wr_lrd, bus.free_valid);
        end
        step();
        bus.free_ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        bus.free_ready = 1'b1;
        bus.flush = 1'b1;
        set_head(1'b1, 32'h500, 5'd2, 6'd14, 6'd15);
        #1;
        vecs++;
        if (bus.head_pop !== 1'b0) begin
            errs++; $display("FAIL flush_pop got %b want 0", bus.head_pop);
        end
        step();
        bus.flush = 1'b0;
        #1;
        vecs++;
        if ({bus.commit_valid, bus.head_pop} !== 2'b01) begin
            errs++; $display("FAIL flush_resume got cv=%b pop=%b want 0 1",
                bus.commit_valid, bus.head_pop);
        end
        step();
        exp_ir = exp_ir + 1;
        bus.free_ready = 1'b0;
        bus.flush = 1'b1;
        step();
        step();
        vecs++;
        if ({bus.free_valid, bus.free_preg, bus.head_pop} !== {1'b1, 6'd15, 1'b0}) begin
            errs++; $display("FAIL flush_wait got fv=%b preg=%0d pop=%b want 1 15 0",
                bus.free_valid, bus.free_preg, bus.head_pop);
        end
        bus.free_ready = 1'b1;
        step();
        vecs++;
        if ({bus.free_valid, bus.head_pop, bus.instret} !== {1'b0, 1'b0, exp_ir}) begin
            errs++; $display("FAIL flush_done got fv=%b pop=%b ir=%0d want 0 0 %0d",
                bus.free_valid, bus.head_pop, bus.instret, exp_ir);
        end
        bus.flush = 1'b0;
        set_head(1'b0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.free_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_head(1'b1, 32'h600 + 4 * i, 5'd1, 6'd5, 6'd6);
            if (i == 15) begin
                vecs++;
                if (bus.instret !== 4'd15) begin
                    errs++; $display("FAIL wrap_15 got %0d want 15", bus.instret);
                end
            end
            step();
        end
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if (bus.instret !== 4'd0) begin
            errs++; $display("FAIL wrap_16 got %0d want 0", bus.instret);
        end
        step();
    endtask

    task automatic test_reset_waitfree();
        bus.free_ready = 1'b0;
        set_head(1'b1, 32'h700, 5'd4, 6'd17, 6'd22);
        step();
        set_head(1'b1, 32'h704, 5'd6, 6'd18, 6'd23);
        step();
        vecs++;
        if ({bus.free_valid, bus.free_preg, bus.instret} !== {1'b1, 6'd22, 4'd1}) begin
            errs++; $display("FAIL rstw_pending got fv=%b preg=%0d ir=%0d want 1 22 1",
                bus.free_valid, bus.free_preg, bus.instret);
        end
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if ({bus.free_valid, bus.commit_valid, bus.arat_wr_en, bus.head_pop} !== 4'b0000 ||
            bus.free_preg !== 6'd0 || bus.instret !== 4'd0 || bus.arat_wr_prd !== 6'd0) begin
            errs++; $display("FAIL rstw_async got fv=%b cv=%b we=%b pop=%b preg=%0d ir=%0d want all 0",
                bus.free_valid, bus.commit_valid, bus.arat_wr_en, bus.head_pop,
                bus.free_preg, bus.instret);
        end
        step();
        reset = 1'b0;
        bus.free_ready = 1'b1;
        #1;
        vecs++;
        if ({bus.free_valid, bus.head_pop} !== 2'b01) begin
            errs++; $display("FAIL rstw_after got fv=%b pop=%b want 0 1",
                bus.free_valid, bus.head_pop);
        end
        step();
        set_head(1'b0, 0, 0, 0, 0);
        #1;
        vecs++;
        if ({bus.commit_valid, bus.arat_wr_lrd, bus.instret} !== {1'b1, 5'd6, 4'd1}) begin
            errs++; $display("FAIL rstw_first got cv=%b lrd=%0d ir=%0d want 1 6 1",
                bus.commit_valid, bus.arat_wr_lrd, bus.instret);
        end
        step();
    endtask

    initial begin
        set_head(1'b0, 0, 0, 0, 0);
        bus.flush = 1'b0;
        bus.free_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_x0();
        test_flush();
        test_wrap();
        test_reset_waitfree();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
